// File: rtl/inst_align_buffer.sv
// Purpose: realigns word-aligned 32-bit fetch words into 16-bit RVC parcels or 32-bit instructions.
// Latency: a word accepted in cycle N is presented in cycle N+1 (later if older halfwords are queued).
// Backpressure: in_ready needs two free halfword slots (registered count only); out_valid waits for a complete instruction.
module inst_align_buffer #(
  parameter int XLEN   = 64,
  parameter int QDEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic            out_is_c,
  output logic [XLEN-1:0] out_pc
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [15:0]     half;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          q_q [QDEPTH];
  entry_t          q_d [QDEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  entry_t          h0;
  logic [15:0]     h1_half;
  logic            is16;
  logic            push, pop;
  logic [CW-1:0]   npush, npop;

  // Head decode and handshake qualification from registered queue state.
  always_comb begin
    h0        = q_q[rd_ptr_q];
    h1_half   = q_q[rd_ptr_q + PW'(1)].half;
    is16      = (h0.half[1:0] != 2'b11);
    in_ready  = ~flush & ((CW'(QDEPTH) - cnt_q) >= CW'(2));
    out_valid = ~flush & ((is16 & (cnt_q >= CW'(1))) | (~is16 & (cnt_q >= CW'(2))));
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    npush     = push ? (in_pc[1] ? CW'(1) : CW'(2)) : CW'(0);
    npop      = pop ? (is16 ? CW'(1) : CW'(2)) : CW'(0);
  end

  // Output formatting: RVC parcels are zero-extended, full instructions join two halves.
  always_comb begin
    out_inst = is16 ? {16'h0000, h0.half} : {h1_half, h0.half};
    out_is_c = out_valid & is16;
    out_pc   = h0.pc;
  end

  // Next queue contents, pointers and count; flush discards everything queued.
  always_comb begin
    q_d      = q_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end else begin
      if (push) begin
        if (in_pc[1]) begin
          // Entry into the upper half of a word: only the upper parcel is ours.
          q_d[wr_ptr_q] = '{half: in_data[31:16], pc: in_pc};
        end else begin
          q_d[wr_ptr_q]          = '{half: in_data[15:0],  pc: {in_pc[XLEN-1:2], 2'b00}};
          q_d[wr_ptr_q + PW'(1)] = '{half: in_data[31:16], pc: {in_pc[XLEN-1:2], 2'b10}};
        end
      end
      wr_ptr_d = wr_ptr_q + PW'(npush);
      rd_ptr_d = rd_ptr_q + PW'(npop);
      cnt_d    = cnt_q + npush - npop;
    end
  end

  // Queue state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_q[i] <= q_d[i];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_align_buffer.sv
// Purpose: scoreboard bench for inst_align_buffer using directed fetch vectors.
// Latency: checks first-output timing and the straddle hold; monitor compares each handshake.
// Backpressure: exercises out_ready=0 fill, in_ready drop/return, flush and reset mid-straddle.
module tb_inst_align_buffer;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_data;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic            out_is_c;
  logic [XLEN-1:0] out_pc;

  typedef struct {
    logic [31:0]     inst;
    logic            is_c;
    logic [XLEN-1:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  inst_align_buffer #(.XLEN(XLEN), .QDEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_is_c  (out_is_c),
    .out_pc    (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_inst(input logic [31:0] inst, input logic is_c, input logic [XLEN-1:0] pc);
    exp_t e;
    e.inst = inst;
    e.is_c = is_c;
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: every completed output handshake is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {out_inst, 31'd0, out_is_c}, 64'hdead_beef_dead_beef);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_inst", {32'd0, out_inst}, {32'd0, e.inst});
        chk("out_is_c", {63'd0, out_is_c}, {63'd0, e.is_c});
        chk("out_pc", out_pc, e.pc);
      end
    end
  end

  // Drive one fetch word; waits (bounded) for in_ready, returns #1 after the accepting edge.
  task automatic push_word(input logic [31:0] data, input logic [XLEN-1:0] pc);
    int n;
    in_valid = 1'b1;
    in_data  = data;
    in_pc    = pc;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("push_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. reset state
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_is_c", {63'd0, out_is_c}, 64'd0);
    chk("rst_out_inst", {32'd0, out_inst}, 64'd0);

    // 2. two RVC parcels from one aligned word, first visible the cycle after acceptance
    @(posedge clk);
    #1 out_ready = 1'b1;
    expect_inst(32'h0000_4501, 1'b1, 64'h8000_0000);
    expect_inst(32'h0000_0505, 1'b1, 64'h8000_0002);
    push_word(32'h0505_4501, 64'h8000_0000);
    @(negedge clk);
    chk("lat_out_valid", {63'd0, out_valid}, 64'd1);
    wait_drain();

    // 3. straddle: the 32-bit half waits for the next word
    expect_inst(32'h0000_4501, 1'b1, 64'h8000_0000);
    expect_inst(32'h0000_0013, 1'b0, 64'h8000_0002);
    expect_inst(32'h0000_4505, 1'b1, 64'h8000_0006);
    push_word(32'h0013_4501, 64'h8000_0000);
    repeat (3) @(negedge clk);
    chk("straddle_hold_valid", {63'd0, out_valid}, 64'd0);
    chk("straddle_hold_q", 64'(exp_q.size()), 64'd2);
    @(posedge clk);
    #1;
    push_word(32'h4505_0000, 64'h8000_0004);
    wait_drain();

    // 4. misaligned entry pushes only the upper half
    expect_inst(32'h0000_0505, 1'b1, 64'h8000_0002);
    push_word(32'h0505_4501, 64'h8000_0002);
    wait_drain();
    @(negedge clk);
    chk("misal_empty_valid", {63'd0, out_valid}, 64'd0);
    chk("misal_in_ready", {63'd0, in_ready}, 64'd1);

    // 5. backpressure: fill, hold, then drain in order
    @(posedge clk);
    #1 out_ready = 1'b0;
    expect_inst(32'h0000_4501, 1'b1, 64'h8000_0010);
    expect_inst(32'h0000_4505, 1'b1, 64'h8000_0012);
    expect_inst(32'h0000_4511, 1'b1, 64'h8000_0014);
    expect_inst(32'h0000_4509, 1'b1, 64'h8000_0016);
    push_word(32'h4505_4501, 64'h8000_0010);
    @(negedge clk);
    chk("bp_in_ready_cnt2", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    push_word(32'h4509_4511, 64'h8000_0014);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_inst", {32'd0, out_inst}, 64'h4501);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_cnt3", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("bp_in_ready_cnt2b", {63'd0, in_ready}, 64'd1);
    wait_drain();

    // 6. flush mid-straddle, then redirect
    push_word(32'h0013_0000, 64'h8000_0022);
    @(negedge clk);
    chk("fl_lone_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("fl_after_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_after_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    expect_inst(32'h0000_0000, 1'b1, 64'h9000_0000);
    expect_inst(32'h0000_4501, 1'b1, 64'h9000_0002);
    push_word(32'h4501_0000, 64'h9000_0000);
    wait_drain();

    // reset during a straddle empties the queue immediately
    push_word(32'h0013_0000, 64'h8000_0032);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_inst(32'h0000_0000, 1'b1, 64'h8000_0034);
    expect_inst(32'h0000_4505, 1'b1, 64'h8000_0036);
    push_word(32'h4505_0000, 64'h8000_0034);
    wait_drain();

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
